// File: rtl/spi_reg_ctrl.sv
// Transaction controller behind an SPI slave byte engine: command/address/data parsing and register bus.
// Optional address auto-increment when SPI_REG_AUTOINC_EN is defined (otherwise fixed FIFO-style address).
module spi_reg_ctrl #(
   parameter int          ADDR_W   = 4,
   parameter int          NUM_REGS = 16,
   parameter logic [7:0]  RD_FILL  = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ssel_active,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              tx_load,
   output logic [7:0]        tx_byte,
   output logic              reg_wr,
   output logic              reg_rd,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_RFETCH,
      ST_RLOAD,
      ST_RDATA
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_wr_adv;
   logic                r_tx_load;
   logic [7:0]          r_tx_byte;
   logic                r_reg_wr;
   logic                r_reg_rd;
   logic [7:0]          r_reg_wdata;
   logic                r_busy;
   logic                r_err;

   logic [ADDR_W-1:0]   w_adv_addr;
   logic [ADDR_W-1:0]   w_wr_base;
   logic [ADDR_W-1:0]   w_cmd_addr;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(NUM_REGS);
   endfunction

`ifdef SPI_REG_AUTOINC_EN
   assign w_adv_addr = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
`else
   assign w_adv_addr = r_addr;
`endif

   // A write strobe is issued at the current address; the advance lands the cycle after it.
   assign w_wr_base  = r_wr_adv ? w_adv_addr : r_addr;
   assign w_cmd_addr = rx_byte[ADDR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_wr_adv    <= 1'b0;
         r_tx_load   <= 1'b0;
         r_tx_byte   <= 8'h00;
         r_reg_wr    <= 1'b0;
         r_reg_rd    <= 1'b0;
         r_reg_wdata <= 8'h00;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle, so any branch that raises one yields a single-cycle pulse.
         r_tx_load <= 1'b0;
         r_reg_wr  <= 1'b0;
         r_reg_rd  <= 1'b0;
         r_wr_adv  <= 1'b0;
         if (!ssel_active) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_CMD;
                  r_busy  <= 1'b1;
               end
               ST_CMD: begin
                  if (rx_valid) begin
                     r_addr <= w_cmd_addr;
                     if (rx_byte[7]) begin
                        r_state  <= ST_RFETCH;
                        r_reg_rd <= in_range(w_cmd_addr);
                        if (!in_range(w_cmd_addr)) r_err <= 1'b1;
                     end else begin
                        r_state <= ST_WDATA;
                     end
                  end
               end
               ST_WDATA: begin
                  r_addr <= w_wr_base;
                  if (rx_valid) begin
                     r_reg_wr    <= in_range(w_wr_base);
                     r_reg_wdata <= rx_byte;
                     r_wr_adv    <= 1'b1;
                     if (!in_range(w_wr_base)) r_err <= 1'b1;
                  end
               end
               ST_RFETCH: begin
                  r_state <= ST_RLOAD;
                  if (rx_valid) r_err <= 1'b1;
               end
               ST_RLOAD: begin
                  r_tx_byte <= in_range(r_addr) ? reg_rdata : RD_FILL;
                  r_tx_load <= 1'b1;
                  r_state   <= ST_RDATA;
                  if (rx_valid) r_err <= 1'b1;
               end
               ST_RDATA: begin
                  if (rx_valid) begin
                     r_addr   <= w_adv_addr;
                     r_reg_rd <= in_range(w_adv_addr);
                     if (!in_range(w_adv_addr)) r_err <= 1'b1;
                     r_state  <= ST_RFETCH;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign tx_load   = r_tx_load;
   assign tx_byte   = r_tx_byte;
   assign reg_wr    = r_reg_wr;
   assign reg_rd    = r_reg_rd;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_reg_wdata;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule
